// File: rtl/pcw_tick_timer.sv
// PCW 300 Hz tick timer: exact fractional divider on the 1 MHz enable, a
// saturating pending-tick counter with clear-on-read, and a maskable interrupt.
module pcw_tick_timer #(
    parameter int INC     = 3,
    parameter int MODULUS = 10000,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_1mhz,
    input  logic       rd_stb,
    input  logic       int_en_set,
    input  logic       int_en_clr,
    output logic [7:0] rd_data,
    output logic       tick,
    output logic       int_n,
    output logic       int_en
);

    localparam int               PH_W    = $clog2(MODULUS + INC);
    localparam logic [PH_W-1:0]  INC_V   = PH_W'(INC);
    localparam logic [PH_W-1:0]  MOD_V   = PH_W'(MODULUS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PH_W-1:0]  phase_r;
    logic [PH_W-1:0]  sum_s;
    logic [PH_W-1:0]  phase_nxt_s;
    logic             wrap_s;
    logic             tick_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             int_en_r;
    logic             int_en_nxt_s;
    logic             int_n_r;
    logic [7:0]       rd_data_r;

    // Status byte as seen by the CPU: overflow in bit 7, count in the low bits.
    function automatic logic [7:0] pack_status(input logic ovf, input logic [CNT_W-1:0] cnt);
        return {ovf, {(7 - CNT_W){1'b0}}, cnt};
    endfunction

    // Next phase: the remainder is kept on wrap so the average rate is exact.
    always_comb begin
        sum_s  = phase_r + INC_V;
        wrap_s = (sum_s >= MOD_V);
        if (wrap_s) begin
            phase_nxt_s = sum_s - MOD_V;
        end else begin
            phase_nxt_s = sum_s;
        end
    end

    // Phase accumulator and single-cycle tick pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= {PH_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (ce_1mhz) begin
            phase_r <= phase_nxt_s;
            tick_r  <= wrap_s;
        end else begin
            tick_r  <= 1'b0;
        end
    end

    // Pending-tick count; a tick coinciding with a read becomes the first new tick.
    always_comb begin
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r;
        if (rd_stb) begin
            count_nxt_s    = tick_r ? CNT_ONE : {CNT_W{1'b0}};
            overflow_nxt_s = 1'b0;
        end else if (tick_r) begin
            if (count_r != CNT_MAX) begin
                count_nxt_s = count_r + CNT_ONE;
            end else begin
                overflow_nxt_s = 1'b1;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Interrupt enable: clear has priority over set.
    always_comb begin
        if (int_en_clr) begin
            int_en_nxt_s = 1'b0;
        end else if (int_en_set) begin
            int_en_nxt_s = 1'b1;
        end else begin
            int_en_nxt_s = int_en_r;
        end
    end

    // Counter, enable, interrupt and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            int_en_r   <= 1'b0;
            int_n_r    <= 1'b1;
            rd_data_r  <= 8'h00;
        end else begin
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
            int_en_r   <= int_en_nxt_s;
            int_n_r    <= ~(int_en_r & (count_r != {CNT_W{1'b0}}));
            if (rd_stb) begin
                rd_data_r <= pack_status(overflow_r, count_r);
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign tick    = tick_r;
    assign int_n   = int_n_r;
    assign int_en  = int_en_r;
    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_pcw_tick_timer.sv
// Bench for pcw_tick_timer: a full-rate instance checks tick timing, a
// fast-modulus instance (tick every 13/13/14 pulses) checks counter and interrupt.
module tb_pcw_tick_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_1mhz = 1'b0;
    logic       rd_stb = 1'b0;
    logic       int_en_set = 1'b0;
    logic       int_en_clr = 1'b0;
    logic [7:0] d_rd_data, f_rd_data;
    logic       d_tick, f_tick, d_int_n, f_int_n, d_int_en, f_int_en;

    int tests = 0;
    int fails = 0;
    int ce_seen;
    int d_ticks = 0;
    int f_ticks = 0;
    logic rd_seen;
    int         d_q[$];
    logic [7:0] rd_q[$];

    pcw_tick_timer dut_d (
        .clk(clk), .reset(reset), .ce_1mhz(ce_1mhz), .rd_stb(rd_stb),
        .int_en_set(int_en_set), .int_en_clr(int_en_clr),
        .rd_data(d_rd_data), .tick(d_tick), .int_n(d_int_n), .int_en(d_int_en)
    );

    pcw_tick_timer #(.INC(3), .MODULUS(40), .CNT_W(4)) dut_f (
        .clk(clk), .reset(reset), .ce_1mhz(ce_1mhz), .rd_stb(rd_stb),
        .int_en_set(int_en_set), .int_en_clr(int_en_clr),
        .rd_data(f_rd_data), .tick(f_tick), .int_n(f_int_n), .int_en(f_int_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count accepted enables and note read strobes as the DUT samples them.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_seen <= 0;
            rd_seen <= 1'b0;
        end else begin
            if (ce_1mhz) ce_seen <= ce_seen + 1;
            rd_seen <= rd_stb;
        end
    end

    // Scoreboard: pop expected tick pulse numbers and read values as outputs appear.
    always @(negedge clk) begin
        if (d_tick === 1'b1) begin
            d_ticks++;
            tests++;
            assert (d_q.size() != 0) else begin
                fails++;
                $error("FAIL d_tick_unexpected: observed tick at pulse %0d expected none", ce_seen);
            end
            if (d_q.size() != 0) check("d_tick_pulse", ce_seen, d_q.pop_front());
        end
        if (f_tick === 1'b1) f_ticks++;
        if (rd_seen) begin
            tests++;
            assert (rd_q.size() != 0) else begin
                fails++;
                $error("FAIL rd_unexpected: observed %0h expected no read", f_rd_data);
            end
            if (rd_q.size() != 0) check("rd_data", f_rd_data, rd_q.pop_front());
        end
    end

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ce_1mhz = 1'b1;
        end
        @(posedge clk); #1 ce_1mhz = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic strobe_rd(input logic [7:0] exp);
        @(posedge clk); #1 rd_stb = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk); #1 rd_stb = 1'b0;
    endtask

    task automatic strobe_en(input logic set, input logic clr);
        @(posedge clk); #1 int_en_set = set; int_en_clr = clr;
        @(posedge clk); #1 int_en_set = 1'b0; int_en_clr = 1'b0;
    endtask

    task automatic run_fticks(input int n);
        int target;
        int budget;
        target = f_ticks + n;
        budget = 20 * n + 50;
        while (f_ticks < target && budget > 0) begin
            @(posedge clk); #1 ce_1mhz = 1'b1;
            budget--;
        end
        @(posedge clk); #1 ce_1mhz = 1'b0;
        check("ftick_budget", (f_ticks >= target) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #3 reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #22;
        check("rst_d_tick", d_tick, 0);
        check("rst_d_int_n", d_int_n, 1);
        check("rst_d_int_en", d_int_en, 0);
        check("rst_d_rd_data", d_rd_data, 8'h00);
        check("rst_f_int_n", f_int_n, 1);
        @(posedge clk); #3 reset = 1'b0;

        // Drift-free divider: ticks at 3334, 6667, 10000, then 13334 from phase 0.
        d_q.push_back(3334);
        d_q.push_back(6667);
        d_q.push_back(10000);
        d_q.push_back(13334);
        pulses(10000);
        idle(2);
        check("d_ticks_10000", d_ticks, 3);
        check("d_q_left_10000", d_q.size(), 1);
        pulses(3334);
        idle(2);
        check("d_ticks_13334", d_ticks, 4);
        check("d_q_empty_13334", d_q.size(), 0);

        // One tick with interrupt enabled, then clear by read.
        do_reset();
        strobe_en(1'b1, 1'b0);
        @(negedge clk);
        check("int_en_set", f_int_en, 1);
        check("int_n_no_count", f_int_n, 1);
        run_fticks(1);
        idle(3);
        check("int_n_one_tick", f_int_n, 0);
        strobe_rd(8'h01);
        @(negedge clk);
        check("int_n_read_c1", f_int_n, 0);
        @(negedge clk);
        check("int_n_read_c2", f_int_n, 1);

        // Saturation and sticky overflow with interrupt disabled.
        strobe_en(1'b0, 1'b1);
        @(negedge clk);
        check("int_en_clr", f_int_en, 0);
        run_fticks(20);
        idle(3);
        check("int_n_disabled_full", f_int_n, 1);
        strobe_rd(8'h8F);
        strobe_rd(8'h00);
        idle(2);

        // Read on the same cycle as the 6th tick (pulse 80) with count 5.
        do_reset();
        strobe_en(1'b1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1 ce_1mhz = 1'b1;
        end
        @(posedge clk); #1 ce_1mhz = 1'b0; rd_stb = 1'b1;
        rd_q.push_back(8'h05);
        @(negedge clk);
        check("tick_aligned_with_rd", f_tick, 1);
        @(posedge clk); #1 rd_stb = 1'b0;
        @(negedge clk);
        check("int_n_same_cycle_c1", f_int_n, 0);
        @(negedge clk);
        check("int_n_same_cycle_c2", f_int_n, 0);
        strobe_rd(8'h01);
        idle(3);
        check("int_n_after_clear", f_int_n, 1);

        // Enable strobes with count 3.
        do_reset();
        pulses(40);
        idle(2);
        check("int_n_count3_disabled", f_int_n, 1);
        strobe_en(1'b1, 1'b1);
        @(negedge clk);
        check("int_en_clear_wins", f_int_en, 0);
        @(negedge clk);
        check("int_n_clear_wins", f_int_n, 1);
        strobe_en(1'b1, 1'b0);
        @(negedge clk);
        check("int_en_set_c1", f_int_en, 1);
        check("int_n_set_c1", f_int_n, 1);
        @(negedge clk);
        check("int_n_set_c2", f_int_n, 0);
        strobe_en(1'b0, 1'b1);
        @(negedge clk);
        check("int_en_clr_c1", f_int_en, 0);
        check("int_n_clr_c1", f_int_n, 0);
        @(negedge clk);
        check("int_n_clr_c2", f_int_n, 1);
        strobe_rd(8'h03);

        // Asynchronous reset mid-period with count 7 and interrupt enabled.
        do_reset();
        strobe_en(1'b1, 1'b0);
        pulses(40);
        strobe_rd(8'h03);
        pulses(94);
        idle(3);
        check("int_n_count7", f_int_n, 0);
        check("rd_data_hold", f_rd_data, 8'h03);
        check("d_q_empty_pre_reset", d_q.size(), 0);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("async_int_n", f_int_n, 1);
        check("async_rd_data", f_rd_data, 8'h00);
        check("async_int_en", f_int_en, 0);
        check("async_tick", f_tick, 0);
        @(posedge clk); #3 reset = 1'b0;
        d_q.push_back(3334);
        strobe_rd(8'h00);
        pulses(3334);
        idle(3);
        check("d_q_empty_after_reset", d_q.size(), 0);
        check("d_ticks_total", d_ticks, 5);
        check("rd_q_empty", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 5 ms");
        $fatal(1, "watchdog");
    end

endmodule
